// File: rtl/hs_bridge_pkg.sv
// Shared types and constants for the handshake sampler bridge.
package hs_bridge_pkg;

    // Width of the asynchronous counter value carried on dout.
    localparam int CNT_W = 4;

    // Number of cycles the counter clear is held low before sampling starts.
    localparam int CLR_CYCLES = 2;

    // Handshake controller states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_HOLD  = 3'd2,
        S_REQ   = 3'd3,
        S_CAPT  = 3'd4,
        S_REL   = 3'd5,
        S_ERR   = 3'd6
    } BridgeState;

endpackage

// File: rtl/hs_sync.sv
// N-flop single-bit synchroniser with asynchronous active-low reset to 0.
module hs_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/hs_sampler_bridge.sv
// Clocked four-phase master for the self-timed counter: clears it, requests
// counts, captures dout under bundled-data timing and queues samples in a
// small first-word-fall-through FIFO.
module hs_sampler_bridge
    import hs_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              run_i,
    output logic                              clr_n_o,
    output logic                              start_o,
    input  logic                              ack_i,
    input  logic [CNT_W-1:0]                  dout_i,
    input  logic                              rd_i,
    output logic [CNT_W-1:0]                  data_o,
    output logic                              valid_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
    output logic                              busy_o,
    output logic                              timeout_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    localparam logic [7:0]    WAIT_LAST  = 8'(TIMEOUT);
    localparam logic [1:0]    CLR_LAST   = 2'(CLR_CYCLES - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    BridgeState state_q, state_d;

    logic [1:0] clrCnt_q, clrCnt_d;
    logic [7:0] waitCnt_q, waitCnt_d;

    logic start_q, start_d;
    logic clrN_q, clrN_d;
    logic busy_q, busy_d;
    logic timeout_q, timeout_d;

    logic ackSync;

    logic [CNT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wrPtr_q, rdPtr_q;
    logic [LW-1:0]    count_q, count_d;
    logic             valid_q;

    logic push, pop, full;

    hs_sync #(
        .STAGES (SYNC_STAGES)
    ) uAckSync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ack_i),
        .q_o   (ackSync)
    );

    assign full = (count_q == FULL_LEVEL);
    assign push = (state_q == S_CAPT) && !full;
    assign pop  = rd_i && (count_q != '0);

    // Next-state logic for the handshake controller and its registered outputs.
    always_comb begin
        state_d   = state_q;
        clrCnt_d  = clrCnt_q;
        waitCnt_d = waitCnt_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                clrCnt_d = '0;
                if (run_i && !timeout_q) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clrCnt_q == CLR_LAST) begin
                    state_d = S_HOLD;
                end else begin
                    clrCnt_d = clrCnt_q + 2'd1;
                end
            end
            S_HOLD: begin
                if (!run_i) begin
                    state_d = S_IDLE;
                end else if (!full && !ackSync) begin
                    state_d   = S_REQ;
                    waitCnt_d = '0;
                end
            end
            S_REQ: begin
                if (ackSync) begin
                    state_d = S_CAPT;
                end else if (waitCnt_q == WAIT_LAST) begin
                    state_d   = S_ERR;
                    timeout_d = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            S_CAPT: begin
                state_d   = S_REL;
                waitCnt_d = '0;
            end
            S_REL: begin
                if (!ackSync) begin
                    state_d = S_HOLD;
                end else if (waitCnt_q == WAIT_LAST) begin
                    state_d   = S_ERR;
                    timeout_d = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            S_ERR: begin
                if (!run_i && !ackSync) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_d = (state_d == S_REQ) || (state_d == S_CAPT);
        clrN_d  = (state_d != S_CLEAR);
        busy_d  = (state_d != S_IDLE);
    end

    // Controller state and output registers; reset holds the counter clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            clrCnt_q  <= '0;
            waitCnt_q <= '0;
            start_q   <= 1'b0;
            clrN_q    <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clrCnt_q  <= clrCnt_d;
            waitCnt_q <= waitCnt_d;
            start_q   <= start_d;
            clrN_q    <= clrN_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // Sample storage and pointers; reset discards every queued sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wrPtr_q] <= dout_i;
                wrPtr_q        <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    assign start_o   = start_q;
    assign clr_n_o   = clrN_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;
    assign data_o    = mem_q[rdPtr_q];
    assign valid_o   = valid_q;
    assign level_o   = count_q;

endmodule

// File: tb/tb_hs_sampler_bridge.sv
// Bench for hs_sampler_bridge: a behavioural counter answers the four-phase
// requests, a queue model tracks what the FIFO must hold, and directed
// scenarios pin clear length, full back-pressure, wrap, run drop, same-cycle
// push/pop, reset mid-handshake and the handshake timeout.
module tb_hs_sampler_bridge;

    localparam int SYNC  = 2;
    localparam int TOUT  = 20;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       run_i;
    logic       clr_n_o;
    logic       start_o;
    logic       ack_i;
    logic [3:0] dout_i;
    logic       rd_i;
    logic [3:0] data_o;
    logic       valid_o;
    logic [2:0] level_o;
    logic       busy_o;
    logic       timeout_o;

    int passCnt  = 0;
    int totalCnt = 0;

    bit ackEnable = 1'b1;

    logic [3:0] mq[$];
    logic [3:0] pendVal;
    int         mTimer;
    logic       prevAck;

    hs_sampler_bridge #(
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TOUT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (run_i),
        .clr_n_o   (clr_n_o),
        .start_o   (start_o),
        .ack_i     (ack_i),
        .dout_i    (dout_i),
        .rd_i      (rd_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .level_o   (level_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        totalCnt++;
        if (actual == expected) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic run, input logic rd);
        run_i = run;
        rd_i  = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic popOne();
        applyStimulus(run_i, 1'b1);
        tick();
        applyStimulus(run_i, 1'b0);
    endtask

    task automatic waitLevel(input int lvl, input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (int'(level_o) == lvl) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkOutput(name, int'(found), 1);
    endtask

    task automatic waitIdle(input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy_o) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkOutput(name, int'(found), 1);
    endtask

    // Self-timed counter: ack follows start three cycles later, count steps once per handshake.
    initial begin
        logic [3:0] startHist;
        int         cntVal;
        ack_i     = 1'b0;
        dout_i    = 4'd0;
        startHist = 4'd0;
        cntVal    = 0;
        forever begin
            @(posedge clk);
            #1;
            startHist = {startHist[2:0], start_o};
            if (!clr_n_o) cntVal = 0;
            if (ackEnable && startHist[3]) begin
                if (!ack_i) begin
                    cntVal = (cntVal + 1) % 16;
                    dout_i = 4'(cntVal);
                end
                ack_i = 1'b1;
            end else begin
                ack_i = 1'b0;
            end
        end
    end

    // Expected FIFO contents: a rising ack lands in the queue SYNC+2 edges after it was driven.
    initial begin
        mTimer  = 0;
        prevAck = 1'b1;
        pendVal = 4'd0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                mTimer  = 0;
                prevAck = 1'b1;
            end else begin
                if (rd_i && mq.size() > 0) void'(mq.pop_front());
                if (mTimer == 1) mq.push_back(pendVal);
                if (mTimer > 0) mTimer--;
                if (ack_i && !prevAck) begin
                    mTimer  = SYNC + 1;
                    pendVal = dout_i;
                end
                prevAck = ack_i;
            end
        end
    end

    // FIFO outputs against the queue model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("fifo level", int'(level_o), mq.size());
            checkOutput("fifo valid", int'(valid_o), int'(mq.size() != 0));
            if (mq.size() > 0) checkOutput("fifo head", int'(data_o), int'(mq[0]));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         lowCnt;
        int         highCnt;
        int         reqCnt;
        logic [3:0] popped;
        logic       prevStart;
        bit         found;

        applyStimulus(1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) tick();

        // Reset values.
        checkOutput("reset start_o",   int'(start_o),   0);
        checkOutput("reset clr_n_o",   int'(clr_n_o),   0);
        checkOutput("reset busy_o",    int'(busy_o),    0);
        checkOutput("reset timeout_o", int'(timeout_o), 0);
        checkOutput("reset valid_o",   int'(valid_o),   0);
        checkOutput("reset data_o",    int'(data_o),    0);
        checkOutput("reset level_o",   int'(level_o),   0);

        rst_n = 1'b1;
        repeat (2) tick();
        checkOutput("idle clr_n_o", int'(clr_n_o), 1);
        checkOutput("idle busy_o",  int'(busy_o),  0);

        // Start sampling: clear lasts exactly two cycles.
        applyStimulus(1'b1, 1'b0);
        lowCnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!clr_n_o) lowCnt++;
        end
        checkOutput("clear cycles", lowCnt, 2);

        // Fill to full: head is the first count and no request while full.
        waitLevel(4, 300, "fill to 4");
        checkOutput("full head", int'(data_o), 1);
        highCnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (start_o) highCnt++;
        end
        checkOutput("start while full", highCnt, 0);
        checkOutput("level while full", int'(level_o), 4);

        // Slow reader: 18 pops, values 1..15, 0, 1, 2.
        for (int k = 0; k < 18; k++) begin
            repeat (19) tick();
            if (valid_o) begin
                popped = data_o;
                popOne();
            end else begin
                popped = 4'hx;
                tick();
            end
            checkOutput($sformatf("pop seq %0d", k), int'(popped), (k + 1) % 16);
        end

        // Drop run during a request: the handshake finishes and pushes one more.
        waitLevel(4, 100, "refill to 4");
        checkOutput("head before drop", int'(data_o), 3);
        popOne();
        found     = 1'b0;
        prevStart = start_o;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (start_o && !prevStart) begin
                found = 1'b1;
                break;
            end
            prevStart = start_o;
        end
        checkOutput("request seen", int'(found), 1);
        applyStimulus(1'b0, 1'b0);
        waitIdle(200, "idle after run drop");
        checkOutput("level after run drop", int'(level_o), 4);
        checkOutput("start after run drop", int'(start_o), 0);
        repeat (20) tick();
        checkOutput("no push while idle", int'(level_o), 4);
        checkOutput("head after run drop", int'(data_o), 4);

        // Same-cycle push and pop at level 2.
        popOne();
        popOne();
        checkOutput("level before push-pop", int'(level_o), 2);
        checkOutput("head before push-pop", int'(data_o), 6);
        applyStimulus(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (mTimer == 1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("push pending", int'(found), 1);
        popOne();
        checkOutput("level after push-pop", int'(level_o), 2);
        checkOutput("head after push-pop", int'(data_o), 7);

        // Reset in REL with two samples queued.
        applyStimulus(1'b0, 1'b0);
        waitIdle(200, "idle before drain");
        for (int i = 0; i < 10; i++) begin
            if (valid_o) popOne();
        end
        checkOutput("drained level", int'(level_o), 0);
        applyStimulus(1'b1, 1'b0);
        found     = 1'b0;
        prevStart = start_o;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (level_o == 3'd2 && prevStart && !start_o) begin
                found = 1'b1;
                break;
            end
            prevStart = start_o;
        end
        checkOutput("REL with two queued", int'(found), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset start_o", int'(start_o), 0);
        checkOutput("async reset level_o", int'(level_o), 0);
        checkOutput("async reset valid_o", int'(valid_o), 0);

        // Counter never acknowledges: timeout after TOUT+1 request cycles.
        applyStimulus(1'b0, 1'b0);
        ackEnable = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        applyStimulus(1'b1, 1'b0);
        reqCnt = 0;
        found  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (start_o) reqCnt++;
            if (timeout_o) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("timeout seen", int'(found), 1);
        checkOutput("timeout REQ cycles", reqCnt, TOUT + 1);
        checkOutput("timeout start_o", int'(start_o), 0);
        checkOutput("busy in ERR", int'(busy_o), 1);
        applyStimulus(1'b0, 1'b0);
        repeat (5) tick();
        checkOutput("idle after ERR", int'(busy_o), 0);
        checkOutput("timeout sticky", int'(timeout_o), 1);
        applyStimulus(1'b1, 1'b0);
        repeat (10) tick();
        checkOutput("no restart busy", int'(busy_o), 0);
        checkOutput("no restart start", int'(start_o), 0);
        checkOutput("timeout still set", int'(timeout_o), 1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/hs_sampler_bridge.md
# hs_sampler_bridge

Synchronous master that clocks the self-timed dual-rail asynchronous counter. Drives its clear and start request, synchronises its acknowledge, captures the 4-bit count with bundled-data timing, and buffers the samples in a small first-word-fall-through FIFO for synchronous readers. The bridge sits directly downstream of the counter's `ack`/`dout` outputs and upstream of its `clr_n`/`start` inputs, and closes the four-phase loop from the clocked domain.

## Interface
- `SYNC_STAGES`, 2: flip-flops in the `ack_i` synchroniser; legal range 2–3.
- `TIMEOUT`, 255: maximum cycles to wait for an `ack` edge; legal range 1–255.
- `FIFO_DEPTH`, 4: number of sample entries; power of two.
- `clk`  in  1  the single clock.
- `rst_n`  in  1  reset, asynchronous assert, active low. Synchronous deassertion is the top level's job.
- `run_i`  in  1  enables continuous sampling while high.
- `clr_n_o`  out  1  active-low clear to the counter; registered.
- `start_o`  out  1  four-phase request to the counter; registered.
- `ack_i`  in  1  asynchronous acknowledge from the counter.
- `dout_i`  in  4  counter value; guaranteed stable while `ack_i` is high.
- `rd_i`  in  1  pops the FIFO head.
- `data_o`  out  4  FIFO head.
- `valid_o`  out  1  FIFO is not empty.
- `level_o`  out  3  FIFO occupancy, 0–4.
- `busy_o`  out  1  high when the state machine is not in IDLE.
- `timeout_o`  out  1  sticky handshake-timeout flag.

## Operation
- State machine states: IDLE, CLEAR, REQ, CAPT, REL, HOLD, ERR.
- IDLE:
  - `start_o`=0 and `clr_n_o`=1.
  - `run_i`=1 while `timeout_o`=0 moves to CLEAR.
- CLEAR:
  - `clr_n_o`=0 for exactly 2 cycles, then go to HOLD.
- HOLD:
  - Go to REQ when the FIFO is not full and `ack_s`=0, where `ack_s` is the synchronised ack.
  - Go to IDLE if `run_i`=0.
- REQ:
  - `start_o`=1.
  - Wait for `ack_s`=1, then go to CAPT.
- CAPT:
  - One cycle. Push `dout_i` directly into the FIFO, with no synchronisation of `dout_i`; bundled-data rule.
  - Go to REL.
- REL:
  - `start_o`=0.
  - Wait for `ack_s`=0, then go to HOLD.
- Timeout:
  - A wait counter clears on entry to REQ and to REL and increments every cycle in those states.
  - When it reaches `TIMEOUT`: go to ERR, set `timeout_o`, force `start_o`=0.
- ERR:
  - Leave to IDLE only when `run_i`=0 and `ack_s`=0.
  - `timeout_o` clears only on reset, so IDLE will not restart until reset.
- `run_i` falling mid-handshake: the current REQ/CAPT/REL sequence completes, then HOLD exits to IDLE. A four-phase cycle is never abandoned.
- FIFO behaviour:
  - Head is visible on `data_o` when `valid_o`=1.
  - `rd_i` while empty is ignored.
  - Push and pop in the same cycle leave `level_o` unchanged.
  - The FIFO never overflows, because REQ is gated on not-full.
- Counts wrap modulo 16, with no special handling.

## Timing
- Reset values:
  - `start_o`=0, `clr_n_o`=0 (counter held clear), `busy_o`=0, `timeout_o`=0.
  - `valid_o`=0, `data_o`=0, `level_o`=0.
  - FSM in IDLE.
- All outputs are registered, except that `data_o` comes from a FIFO register selected by the read pointer.
- `ack_i` edge to state change: `SYNC_STAGES`+1 cycles.
- Push happens in CAPT. `valid_o`/`level_o` update the cycle after.
- Minimum handshake period, with an ack that responds immediately: 2·`SYNC_STAGES`+4 cycles.
- `rst_n` asserted mid-handshake:
  - `start_o` drops asynchronously.
  - FIFO contents are discarded.

## Structure
- Shared package `hs_bridge_pkg` holds:
  - the state enum;
  - `CLR_CYCLES`=2;
  - the count width 4.
- Sub-module `hs_sync`: a parameterised N-flop bit synchroniser with asynchronous active-low reset to 0, instantiated for `ack_i`.
- FIFO pointers and state machine stay inline.

## Test plan
- Behavioural counter model: ack follows start after 3 cycles and count increments per handshake. Raise `run_i` after reset -> `clr_n_o` is low for 2 cycles, then the FIFO receives 1, 2, 3, 4. `level_o`=4 and `start_o` stays 0 while full.
- From the full state, pop one entry per 20 cycles -> `data_o` reads 1, 2, 3, 4, 5, … with no gaps or duplicates. Continue past the wrap -> after 15 comes 0.
- Model never raises ack -> `timeout_o`=1 after `TIMEOUT`+1 cycles in REQ and `start_o`=0. Dropping `run_i` then gives IDLE, and `timeout_o` stays 1.
- Drop `run_i` in REQ -> the handshake completes, one more sample is pushed, then IDLE with `busy_o`=0.
- Assert `rst_n` low in REL with 2 entries queued -> `start_o`=0, `level_o`=0, `valid_o`=0 immediately.
- Assert `rd_i` on the same cycle as a CAPT push with `level_o`=2 -> `level_o` stays 2 and the head advances.
